// File: rtl/instruction_loader.sv
// Writer side of the instruction-memory load port: packs big-endian UART bytes into
// instruction words and strobes them into the IF-stage memory until the all-zero HALT word.
module instruction_loader #(
  parameter int INSTRUCTION_SIZE  = 32,
  parameter int BYTE_SIZE         = 8,
  parameter int MEM_SIZE_IN_WORDS = 20,
  localparam int COUNT_W          = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_load_start,
  input  logic                        i_rx_valid,
  input  logic [BYTE_SIZE-1:0]        i_rx_data,
  input  logic                        i_full_mem,
  output logic                        o_write_mem,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [COUNT_W-1:0]          o_word_count
);

  localparam int BYTES_PER_WORD = INSTRUCTION_SIZE / BYTE_SIZE;
  localparam int BCNT_W         = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int ASM_W          = INSTRUCTION_SIZE - BYTE_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                      state_reg;
  logic [BCNT_W-1:0]           byte_cnt_reg;
  // Only the first BYTES_PER_WORD-1 bytes need storing; the last byte comes straight off i_rx_data.
  logic [ASM_W-1:0]            asm_reg;
  logic [INSTRUCTION_SIZE-1:0] instr_reg;
  logic                        write_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic                        error_reg;
  logic [COUNT_W-1:0]          word_count_reg;

  logic [INSTRUCTION_SIZE-1:0] word_next;
  logic                        last_byte;

  assign word_next = {asm_reg, i_rx_data};
  assign last_byte = (byte_cnt_reg == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      byte_cnt_reg   <= '0;
      asm_reg        <= '0;
      instr_reg      <= '0;
      write_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      word_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_load_start) begin
            state_reg      <= ST_RECEIVE;
            byte_cnt_reg   <= '0;
            word_count_reg <= '0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            busy_reg       <= 1'b1;
          end
        end

        ST_RECEIVE: begin
          if (i_rx_valid) begin
            asm_reg <= word_next[ASM_W-1:0];
            if (last_byte) begin
              byte_cnt_reg <= '0;
              if (i_full_mem) begin
                state_reg <= ST_ERROR;
                error_reg <= 1'b1;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= ST_WRITE;
                instr_reg <= word_next;
                write_reg <= 1'b1;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end

        ST_WRITE: begin
          write_reg <= 1'b0;
          if (word_count_reg != COUNT_W'(MEM_SIZE_IN_WORDS))
            word_count_reg <= word_count_reg + 1'b1;
          if (instr_reg == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= ST_RECEIVE;
          end
          // A byte landing in the write cycle is byte 0 of the following word.
          if (i_rx_valid) begin
            asm_reg      <= word_next[ASM_W-1:0];
            byte_cnt_reg <= BCNT_W'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          write_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_write_mem   = write_reg;
  assign o_instruction = instr_reg;
  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_error       = error_reg;
  assign o_word_count  = word_count_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: scenario tasks push expected words to a queue and compare
// them against the words captured on each o_write_mem pulse.
module tb_instruction_loader;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_load_start = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_full_mem = 1'b0;
  logic        o_write_mem;
  logic [31:0] o_instruction;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [4:0]  o_word_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] imem [0:19];
  int          imem_wr = 0;

  instruction_loader #(
    .INSTRUCTION_SIZE(32),
    .BYTE_SIZE(8),
    .MEM_SIZE_IN_WORDS(20)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_load_start(i_load_start),
    .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data),
    .i_full_mem(i_full_mem),
    .o_write_mem(o_write_mem),
    .o_instruction(o_instruction),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // One clock; outputs sampled 1 time unit after the edge, write pulses captured as
  // they would be by the instruction memory.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_write_mem === 1'b1) begin
      got_q.push_back(o_instruction);
      if (imem_wr < 20) imem[imem_wr] = o_instruction;
      imem_wr++;
      $display("write  word=%08h count_before=%0d", o_instruction, o_word_count);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_write);
    if (expect_write) exp_q.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic start_session();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    imem_wr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_write_mem, o_instruction, o_busy, o_done, o_error, o_word_count} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b ins=%08h busy=%b done=%b err=%b cnt=%0d want all 0",
               o_write_mem, o_instruction, o_busy, o_done, o_error, o_word_count);
    end
    $display("reset  outputs we=%b busy=%b done=%b err=%b cnt=%0d",
             o_write_mem, o_busy, o_done, o_error, o_word_count);
  endtask

  task automatic test_single_word();
    start_session();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got %b want 1", o_busy);
    end
    send_word(32'h12345678, 1'b1);
    tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_write_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single_word got %08h want %08h", g, e);
      end
    end
    checks++;
    if (o_word_count !== 5'd1 || o_busy !== 1'b1 || o_instruction !== 32'h12345678) begin
      errors++;
      $display("FAIL single_status got cnt=%0d busy=%b ins=%08h want 1 1 12345678",
               o_word_count, o_busy, o_instruction);
    end
  endtask

  task automatic test_halt_session();
    do_reset();
    start_session();
    for (int i = 0; i < 3; i++) send_word($urandom | 32'h1, 1'b1);
    send_word(32'h0, 1'b1);
    tick();
    tick();
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL halt_write_count got %0d want 4", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL halt_word got %08h want %08h", g, e);
      end
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_word_count !== 5'd4 || o_instruction !== 32'h0) begin
      errors++;
      $display("FAIL halt_status got done=%b busy=%b cnt=%0d ins=%08h want 1 0 4 00000000",
               o_done, o_busy, o_word_count, o_instruction);
    end
  endtask

  task automatic test_full_mem();
    got_q.delete();
    start_session();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b1 || o_word_count !== 5'd0) begin
      errors++;
      $display("FAIL restart_clear got done=%b busy=%b cnt=%0d want 0 1 0",
               o_done, o_busy, o_word_count);
    end
    send_word(32'hCAFE0001, 1'b1);
    tick();
    void'(exp_q.pop_front());
    got_q.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    i_full_mem = 1'b1;
    send_byte(8'h44);
    tick();
    i_full_mem = 1'b0;
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL full_no_write got %0d writes want 0", got_q.size());
    end
    checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_word_count !== 5'd1 || o_instruction !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL full_status got err=%b busy=%b cnt=%0d ins=%08h want 1 0 1 cafe0001",
               o_error, o_busy, o_word_count, o_instruction);
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    start_session();
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears_error got %b want 0", o_error);
    end
    exp_q.push_back(32'hAABBCCDD);
    exp_q.push_back(32'hEEFF0011);
    begin
      logic [7:0] seq [8];
      seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11};
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
    end
    tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_write_count got %0d want 2", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_word got %08h want %08h", g, e);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_partial();
    do_reset();
    start_session();
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_reset();
    start_session();
    send_word(32'h01020304, 1'b1);
    tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL partial_write_count got %0d want 1", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL partial_word got %08h want %08h", g, e);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [31:0] loaded [3];
    loaded = '{32'h8C010004, 32'h20420007, 32'h00000000};
    do_reset();
    send_word(32'h55667788, 1'b0);
    tick();
    checks++;
    if (got_q.size() != 0 || o_busy !== 1'b0 || o_word_count !== 5'd0) begin
      errors++;
      $display("FAIL idle_rx_ignored got writes=%0d busy=%b cnt=%0d want 0 0 0",
               got_q.size(), o_busy, o_word_count);
    end
    start_session();
    send_word(loaded[0], 1'b1);
    tick();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_word_count !== 5'd1) begin
      errors++;
      $display("FAIL busy_start_ignored got busy=%b cnt=%0d want 1 1", o_busy, o_word_count);
    end
    send_word(loaded[1], 1'b1);
    send_word(loaded[2], 1'b1);
    tick();
    tick();
    send_word(32'h99999999, 1'b0);
    tick();
    checks++;
    if (got_q.size() != 3 || o_done !== 1'b1 || o_word_count !== 5'd3) begin
      errors++;
      $display("FAIL done_rx_ignored got writes=%0d done=%b cnt=%0d want 3 1 3",
               got_q.size(), o_done, o_word_count);
    end
    // Fetch back from the captured instruction memory in program order.
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem[i] !== loaded[i]) begin
        errors++;
        $display("FAIL fetch_word%0d got %08h want %08h", i, imem[i], loaded[i]);
      end
      $display("fetch  addr=%0d word=%08h", i, imem[i]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_halt_session();
    test_full_mem();
    test_back_to_back();
    test_reset_partial();
    test_ignored_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
